// File: rtl/lane_rr_arbiter8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin lane arbiter.
package lane_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] sel);
    onehot8 = 8'b0000_0001 << sel;
  endfunction

endpackage

// File: rtl/lane_rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the lane arbiter.
interface lane_rr_arbiter8_if;
  import lane_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             switch_p;

  modport master (output en, req, input gnt, sel, busy, switch_p);
  modport slave  (input en, req, output gnt, sel, busy, switch_p);

endinterface

// File: rtl/lane_rr_arbiter8_rr_pick8.sv
// Rotating priority pick: first set bit of mask at or after ptr, wrapping 7 -> 0.
module rr_pick8
  import lane_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [SEL_W-1:0]   off_s;

  // Rotate so ptr lands on bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    dbl_s = {mask, mask};
    rot_s = N_REQ'(dbl_s >> ptr);
    off_s = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
    found = |rot_s;
    idx   = ptr + off_s;
  end

endmodule

// File: rtl/lane_rr_arbiter8.sv
// Round-robin owner selection for one shared 8:1 lane, with quantum-based preemption.
module lane_rr_arbiter8
  import lane_arb_pkg::*;
#(
  parameter int QUANTUM = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  lane_rr_arbiter8_if.slave  bus
);

  localparam int CNT_W = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             switch_q, switch_d;

  logic [N_REQ-1:0] mask_s;
  logic [SEL_W-1:0] pick_ptr_s;
  logic [SEL_W-1:0] idx_s;
  logic             found_s;
  logic             rel_s;
  logic             exp_s;

  // gnt is zero while idle, so one mask serves both the idle pick and the successor pick.
  assign mask_s     = bus.req & ~gnt_q;
  assign pick_ptr_s = (state_q == ST_IDLE) ? ptr_q : (sel_q + 3'd1);
  assign rel_s      = ~bus.req[sel_q];
  assign exp_s      = (QUANTUM != 0) && (hold_q >= CNT_MAX) && (|mask_s);

  rr_pick8 u_pick (
    .mask  (mask_s),
    .ptr   (pick_ptr_s),
    .idx   (idx_s),
    .found (found_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    switch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && found_s) begin
          state_d = ST_GRANT;
          gnt_d   = onehot8(idx_s);
          sel_d   = idx_s;
          busy_d  = 1'b1;
          hold_d  = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_s || exp_s) begin
          ptr_d = sel_q + 3'd1;
          if (bus.en && found_s) begin
            gnt_d    = onehot8(idx_s);
            sel_d    = idx_s;
            hold_d   = CNT_ONE;
            switch_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_q < CNT_MAX) begin
          hold_d = hold_q + CNT_ONE;
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, quantum counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      switch_q <= switch_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.switch_p = switch_q;

endmodule

// File: tb/tb_lane_rr_arbiter8.sv
// Random and directed stimulus on two arbiter instances (QUANTUM 4 and 16) against a behavioural model.
module tb_lane_rr_arbiter8;

  logic clk;
  logic rst_n;

  lane_rr_arbiter8_if a_if ();
  lane_rr_arbiter8_if b_if ();

  lane_rr_arbiter8 #(.QUANTUM(4))  dut_q4  (.clk(clk), .rst_n(rst_n), .bus(a_if));
  lane_rr_arbiter8 #(.QUANTUM(16)) dut_q16 (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       cur_en;
  logic [7:0] cur_req;

  // Model state per instance: owner (-1 = idle), last sel, rotation start, cycles held.
  int m_own [2];
  int m_sel [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_sw  [2];
  int qv    [2] = '{4, 16};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic set_in(input logic en_v, input logic [7:0] req_v);
    cur_en   = en_v;
    cur_req  = req_v;
    a_if.en  = en_v;
    a_if.req = req_v;
    b_if.en  = en_v;
    b_if.req = req_v;
  endtask

  task automatic model_reset();
    for (int q = 0; q < 2; q++) begin
      m_own[q] = -1;
      m_sel[q] = 0;
      m_ptr[q] = 0;
      m_cnt[q] = 0;
      m_sw[q]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int q = 0; q < 2; q++) begin
      logic [7:0] others;
      bit rel, expd;
      others = cur_req;
      m_sw[q] = 0;
      if (m_own[q] < 0) begin
        if (cur_en && cur_req != 8'h00) begin
          m_own[q] = pick(cur_req, m_ptr[q]);
          m_sel[q] = m_own[q];
          m_cnt[q] = 1;
        end
      end else begin
        others[m_own[q]] = 1'b0;
        rel  = !cur_req[m_own[q]];
        expd = (qv[q] != 0) && (m_cnt[q] >= qv[q]) && (others != 8'h00);
        if (rel || expd) begin
          m_ptr[q] = (m_own[q] + 1) % 8;
          if (cur_en && others != 8'h00) begin
            m_own[q] = pick(others, m_ptr[q]);
            m_sel[q] = m_own[q];
            m_cnt[q] = 1;
            m_sw[q]  = 1;
          end else begin
            m_own[q] = -1;
          end
        end else begin
          m_cnt[q] = (m_cnt[q] + 1 > qv[q]) ? qv[q] : m_cnt[q] + 1;
        end
      end
    end
  endtask

  task automatic check_one(input int q, input logic [7:0] g, input logic [2:0] s,
                           input logic b, input logic sw);
    logic [7:0] exp_g;
    string p;
    p     = (q == 0) ? "q4" : "q16";
    exp_g = (m_own[q] >= 0) ? (8'h01 << m_own[q]) : 8'h00;
    chk_eq({p, "_gnt"}, 32'(g), 32'(exp_g));
    chk_eq({p, "_sel"}, 32'(s), 32'(m_sel[q]));
    chk_eq({p, "_busy"}, 32'(b), 32'(m_own[q] >= 0));
    chk_eq({p, "_switch_p"}, 32'(sw), 32'(m_sw[q]));
    chk_eq({p, "_inv_onehot0"}, 32'($onehot0(g)), 32'd1);
    chk_eq({p, "_inv_busy"}, 32'(b), 32'(|g));
    if (b) chk_eq({p, "_inv_gnt_sel"}, 32'(g), 32'(8'h01 << s));
  endtask

  task automatic check_all();
    check_one(0, a_if.gnt, a_if.sel, a_if.busy, a_if.switch_p);
    check_one(1, b_if.gnt, b_if.sel, b_if.busy, b_if.switch_p);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_eq("rst_gnt_q4", 32'(a_if.gnt), 32'h0);
    chk_eq("rst_busy_q4", 32'(a_if.busy), 32'h0);
    chk_eq("rst_gnt_q16", 32'(b_if.gnt), 32'h0);
    chk_eq("rst_busy_q16", 32'(b_if.busy), 32'h0);
    chk_eq("rst_sel_q16", 32'(b_if.sel), 32'h0);
    chk_eq("rst_sw_q16", 32'(b_if.switch_p), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int sw_cnt;
    set_in(1'b0, 8'h00);
    model_reset();
    rst_n = 1'b0;
    #12;
    do_reset();

    // Directed: first grant, then release hands over with switch pulse
    set_in(1'b1, 8'b0001_0010);
    step();
    chk_eq("t1_gnt", 32'(b_if.gnt), 32'h02);
    chk_eq("t1_sel", 32'(b_if.sel), 32'd1);
    set_in(1'b1, 8'b0001_0000);
    step();
    chk_eq("t1_gnt2", 32'(b_if.gnt), 32'h10);
    chk_eq("t1_sw", 32'(b_if.switch_p), 32'd1);

    // Directed: all requesting, quantum 4 rotation
    do_reset();
    set_in(1'b1, 8'hFF);
    sw_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      step();
      if (a_if.switch_p) sw_cnt++;
    end
    chk_eq("t2_q4_switches", 32'(sw_cnt), 32'd8);
    chk_eq("t2_q4_sel_wrapped", 32'(a_if.sel), 32'd0);

    // Directed: wrap 6 -> 7 -> 0
    do_reset();
    set_in(1'b1, 8'b0100_0000);
    step();
    set_in(1'b1, 8'b1000_0001);
    step();
    chk_eq("t3_sel7", 32'(b_if.sel), 32'd7);
    set_in(1'b1, 8'b0000_0001);
    step();
    chk_eq("t3_sel0", 32'(b_if.sel), 32'd0);

    // Directed: lone requester is never preempted, newcomer takes over once quantum is spent
    do_reset();
    set_in(1'b1, 8'b0000_0100);
    for (int i = 0; i < 40; i++) step();
    chk_eq("t4_gnt_hold", 32'(b_if.gnt), 32'h04);
    set_in(1'b1, 8'b0010_0100);
    step();
    chk_eq("t4_gnt5", 32'(b_if.gnt), 32'h20);

    // Directed: en gating
    do_reset();
    set_in(1'b0, 8'h0F);
    for (int i = 0; i < 6; i++) step();
    chk_eq("t5_idle_gnt", 32'(b_if.gnt), 32'h00);
    set_in(1'b1, 8'h0F);
    step();
    chk_eq("t5_gnt0", 32'(b_if.gnt), 32'h01);
    set_in(1'b0, 8'h0E);
    step();
    chk_eq("t5_no_successor", 32'(b_if.gnt), 32'h00);

    // Directed: async reset mid-grant, then scan restarts at 0
    do_reset();
    set_in(1'b1, 8'b0010_0000);
    step();
    chk_eq("t6_sel5", 32'(b_if.sel), 32'd5);
    #2;
    do_reset();
    set_in(1'b1, 8'b0010_0100);
    step();
    chk_eq("t6_gnt2", 32'(b_if.gnt), 32'h04);

    // Random: requests toggle sparsely, en mostly high, occasional reset
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 9) == 0) r[k] = ~r[k];
      end
      set_in(($urandom_range(0, 9) != 0), r);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        do_reset();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
